// File: rtl/vga_pkg.sv
// Shared types and colour constants for the VGA test-pattern datapath.
// Palette and mode encoding are common to the scheduler and the pattern generator.
package vga_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int V_ACTIVE_D = 480;

   typedef enum logic [1:0] {
      BARS     = 2'd0,
      CHECKER  = 2'd1,
      GRADIENT = 2'd2,
      SOLID    = 2'd3
   } mode_t;

   localparam logic [15:0] WHITE   = 16'hFFFF;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] CYAN    = 16'h07FF;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] MAGENTA = 16'hF81F;
   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] BLACK   = 16'h0000;

   // Element 0 is the rightmost entry.
   localparam logic [7:0][15:0] PALETTE = {
      BLACK, BLUE, RED, MAGENTA, GREEN, CYAN, YELLOW, WHITE
   };

endpackage

// File: rtl/vga_pattern_sched_if.sv
// Pixel/control bundle between the timing generator and the pattern scheduler.
// master drives coordinates and requests; slave returns the pixel and status.
interface vga_pattern_sched_if;

   logic        frame_start;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        next_req;
   logic        auto_en;
   logic [15:0] rgb;
   logic        rgb_valid;
   logic [1:0]  mode;
   logic [15:0] frame_cnt;

   modport master (
      output frame_start, pix_valid, pix_x, pix_y,
      output next_req, auto_en,
      input  rgb, rgb_valid, mode, frame_cnt
   );

   modport slave (
      input  frame_start, pix_valid, pix_x, pix_y,
      input  next_req, auto_en,
      output rgb, rgb_valid, mode, frame_cnt
   );

endinterface

// File: rtl/vga_pattern_gen.sv
// Combinational RGB565 pattern generator.
// Colour-bar index comes from a threshold compare chain instead of a divider.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int BAR_W    = H_ACTIVE_D / 8
)(
   input  mode_t       mode,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   input  logic [2:0]  pal_idx,
   output logic [15:0] pattern
);

   logic [2:0] bar;
   logic       in_range;
   logic       unused_y;

   assign in_range = pix_x < 10'(H_ACTIVE);
   assign unused_y = ^{pix_y[9], pix_y[2:0]};

   always_comb begin
      bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (pix_x >= 10'(i * BAR_W)) bar = 3'(i);
      end
   end

   always_comb begin
      pattern = BLACK;
      unique case (mode)
         BARS:     pattern = in_range ? PALETTE[bar] : BLACK;
         CHECKER:  pattern = (pix_x[5] ^ pix_y[5]) ? WHITE : BLACK;
         GRADIENT: pattern = {pix_x[9:5], pix_y[8:3], ~pix_x[9:5]};
         SOLID:    pattern = PALETTE[pal_idx];
         default:  pattern = BLACK;
      endcase
   end

endmodule

// File: rtl/vga_pattern_sched.sv
// Pattern scheduler: switches test pattern on frame boundaries (manual or
// automatic) and registers the generated pixel with one cycle of latency.
module vga_pattern_sched
   import vga_pkg::*;
#(
   parameter int H_ACTIVE        = H_ACTIVE_D,
   parameter int V_ACTIVE        = V_ACTIVE_D,
   parameter int FRAMES_PER_MODE = 60,
   parameter int BAR_W           = H_ACTIVE_D / 8
)(
   input logic clk,
   input logic rst,
   vga_pattern_sched_if.slave bus
);

   localparam logic [15:0] LAST = 16'(FRAMES_PER_MODE - 1);

   if (BAR_W * 8 != H_ACTIVE || V_ACTIVE > 1024 ||
       FRAMES_PER_MODE < 1 || FRAMES_PER_MODE > 65535) begin : g_bad_cfg
      $error("vga_pattern_sched: illegal parameter set");
   end

   logic [1:0]  mode_q, mode_nxt;
   logic [15:0] cnt_q, cnt_nxt;
   logic        pend_q, pend_nxt;
   logic [2:0]  idx_q, idx_nxt;
   logic [15:0] rgb_q;
   logic        vld_q;
   logic [15:0] pattern;
   logic        advance;

   always_comb begin
      advance  = bus.frame_start &
                 (pend_q | bus.next_req | (bus.auto_en & (cnt_q == LAST)));
      mode_nxt = mode_q;
      cnt_nxt  = cnt_q;
      pend_nxt = pend_q;
      idx_nxt  = idx_q;
      if (bus.frame_start) begin
         if (advance) begin
            mode_nxt = mode_q + 2'd1;
            cnt_nxt  = 16'd0;
            pend_nxt = 1'b0;
         end else if (cnt_q != 16'hFFFF) begin
            cnt_nxt = cnt_q + 16'd1;
         end
         // Entering SOLID restarts the palette walk.
         if (advance && mode_q == 2'(GRADIENT)) idx_nxt = 3'd0;
         else if (mode_q == 2'(SOLID))         idx_nxt = idx_q + 3'd1;
      end else if (bus.next_req) begin
         pend_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 2'd0;
         cnt_q  <= 16'd0;
         pend_q <= 1'b0;
         idx_q  <= 3'd0;
         rgb_q  <= 16'h0000;
         vld_q  <= 1'b0;
      end else begin
         mode_q <= mode_nxt;
         cnt_q  <= cnt_nxt;
         pend_q <= pend_nxt;
         idx_q  <= idx_nxt;
         rgb_q  <= bus.pix_valid ? pattern : 16'h0000;
         vld_q  <= bus.pix_valid;
      end
   end

   vga_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .BAR_W    (BAR_W)
   ) u_gen (
      .mode    (mode_t'(mode_q)),
      .pix_x   (bus.pix_x),
      .pix_y   (bus.pix_y),
      .pal_idx (idx_q),
      .pattern (pattern)
   );

   assign bus.rgb       = rgb_q;
   assign bus.rgb_valid = vld_q;
   assign bus.mode      = mode_q;
   assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_vga_pattern_sched.sv
// Bench for vga_pattern_sched: behavioural model feeds a scoreboard queue,
// a monitor pops one entry per clock and compares outputs.
module tb_vga_pattern_sched;

   localparam int FPM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_pattern_sched_if bus();

   vga_pattern_sched #(
      .H_ACTIVE        (640),
      .V_ACTIVE        (480),
      .FRAMES_PER_MODE (FPM),
      .BAR_W           (80)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [15:0] pal [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   typedef struct {
      logic [15:0] rgb;
      logic        vld;
      logic [1:0]  mode;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];

   int m_mode = 0;
   int m_cnt  = 0;
   bit m_pend = 0;
   int m_idx  = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_pix(int m, int x, int y, int idx);
      int r, g, b;
      case (m)
         0: return (x < 640) ? pal[x / 80] : 16'h0000;
         1: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 16'hFFFF : 16'h0000;
         2: begin
            r = (x >> 5) & 31;
            g = (y >> 3) & 63;
            b = 31 - r;
            return 16'((r << 11) | (g << 5) | b);
         end
         default: return pal[idx];
      endcase
   endfunction

   // Reference model: evaluates the pixel with the current mode, then
   // applies the frame-boundary rules.
   always @(posedge clk or posedge rst) begin
      exp_t e;
      bit   adv;
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_pend = 0; m_idx = 0;
         q.delete();
      end else begin
         e.vld = bus.pix_valid;
         e.rgb = bus.pix_valid ?
                 ref_pix(m_mode, int'(bus.pix_x), int'(bus.pix_y), m_idx) :
                 16'h0000;
         if (bus.frame_start) begin
            adv = m_pend || bus.next_req ||
                  (bus.auto_en && m_cnt == FPM - 1);
            if (adv) begin
               if (m_mode == 2)      m_idx = 0;
               else if (m_mode == 3) m_idx = (m_idx + 1) % 8;
               m_mode = (m_mode + 1) % 4;
               m_cnt  = 0;
               m_pend = 0;
            end else begin
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
               if (m_mode == 3)   m_idx = (m_idx + 1) % 8;
            end
         end else if (bus.next_req) begin
            m_pend = 1;
         end
         e.mode = 2'(m_mode);
         e.cnt  = 16'(m_cnt);
         q.push_back(e);
      end
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no entry expected one");
         end else begin
            e = q.pop_front();
            chk("sb_rgb", bus.rgb, e.rgb);
            chk("sb_valid", bus.rgb_valid, e.vld);
            chk("sb_mode", bus.mode, e.mode);
            chk("sb_cnt", bus.frame_cnt, e.cnt);
         end
      end
   end

   task automatic drive(input bit fs, input bit pv, input int x,
                        input int y, input bit nr);
      @(negedge clk);
      bus.frame_start = fs;
      bus.pix_valid   = pv;
      bus.pix_x       = 10'(x);
      bus.pix_y       = 10'(y);
      bus.next_req    = nr;
   endtask

   task automatic pix(input string n, input int x, input int y,
                      input logic [15:0] exp);
      drive(0, 1, x, y, 0);
      @(posedge clk);
      #1;
      chk(n, bus.rgb, exp);
   endtask

   task automatic frame(input bit nr);
      drive(1, 0, 0, 0, nr);
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      bus.frame_start = 0; bus.pix_valid = 0; bus.pix_x = 0;
      bus.pix_y = 0; bus.next_req = 0; bus.auto_en = 0;
      repeat (3) @(negedge clk);
      chk("rst_rgb", bus.rgb, 0);
      chk("rst_valid", bus.rgb_valid, 0);
      chk("rst_mode", bus.mode, 0);
      chk("rst_cnt", bus.frame_cnt, 0);
      rst = 0;

      pix("bars_x0", 0, 0, 16'hFFFF);
      pix("bars_x85", 85, 0, 16'hFFE0);
      pix("bars_x639", 639, 0, 16'h0000);
      drive(0, 0, 100, 0, 0);
      @(posedge clk); #1;
      chk("blank_rgb", bus.rgb, 0);
      chk("blank_valid", bus.rgb_valid, 0);

      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      chk("coalesce_hold", bus.mode, 0);
      frame(0);
      chk("coalesce_mode", bus.mode, 1);
      chk("coalesce_cnt", bus.frame_cnt, 0);

      pix("chk_32_0", 32, 0, 16'hFFFF);
      pix("chk_32_32", 32, 32, 16'h0000);

      frame(1);
      chk("to_grad", bus.mode, 2);
      pix("grad_0_0", 0, 0, 16'h001F);
      pix("grad_639_479", 639, 479, 16'h9F6C);

      drive(0, 0, 0, 0, 1);
      drive(0, 1, 639, 479, 0);
      @(posedge clk); #2;
      rst = 1;
      #1;
      chk("async_rgb", bus.rgb, 0);
      chk("async_valid", bus.rgb_valid, 0);
      chk("async_mode", bus.mode, 0);
      chk("async_cnt", bus.frame_cnt, 0);
      @(negedge clk);
      rst = 0;
      bus.pix_valid = 0;
      frame(0);
      chk("post_rst_mode", bus.mode, 0);
      chk("post_rst_cnt", bus.frame_cnt, 1);

      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      bus.auto_en = 1;
      for (int i = 1; i <= 16; i++) begin
         frame(0);
         chk("auto_mode", bus.mode, 32'((i / FPM) % 4));
      end
      repeat (3) frame(0);
      frame(1);
      chk("auto_plus_req", bus.mode, 1);
      chk("auto_plus_cnt", bus.frame_cnt, 0);

      bus.auto_en = 0;
      frame(1);
      frame(1);
      chk("to_solid", bus.mode, 3);
      pix("solid_k", 10, 10, 16'hFFFF);
      frame(0);
      pix("solid_k1", 10, 10, 16'hFFE0);
      repeat (7) frame(0);
      pix("solid_k8", 10, 10, 16'hFFFF);

      for (int n = 0; n < 3000; n++) begin
         drive(($urandom % 16) == 0, ($urandom % 4) != 0,
               int'($urandom % 704), int'($urandom % 512),
               ($urandom % 20) == 0);
         if ($urandom % 200 == 0) bus.auto_en = ~bus.auto_en;
      end

      drive(0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
